// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encodings shared by the UART receive path.
package uart_pkg;

    localparam int   UART_OSR        = 16;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_PARITYMODE = 1'b0;

    // Receiver states
    localparam logic [2:0] ST_ARM    = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // 2-of-3 vote used when bits are decided from three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so the line reads as idle (mark) while in reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to settle metastability on the incoming line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uartrx.sv
// uartrx: UART receiver, 16 clocks per bit, start + 8 data (LSB first) +
// parity + stop. Delivers each byte with a one-cycle rdsig strobe.
// Build option UART_RX_MAJORITY_EN: decide each bit by 2-of-3 majority of the
// samples at offsets 6, 7, 8; otherwise the single offset-7 sample is used.
// Either way the decision is taken at offset 8, so latency does not change.
module uartrx
    import uart_pkg::*;
#(
    parameter logic PARITYMODE   = UART_PARITYMODE,
    parameter int   CLKS_PER_BIT = UART_OSR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       idle
);

    localparam logic [3:0] SC_LAST  = 4'(CLKS_PER_BIT - 1);
    localparam logic [3:0] ARM_LAST = 4'(UART_OSR - 1);
    localparam logic [2:0] BI_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [3:0] SC_PRE   = 4'd7;
    localparam logic [3:0] SC_MID   = 4'd8;

    logic       rx_s;
    logic [2:0] state;
    logic [3:0] arm_cnt;
    logic [3:0] sc;
    logic [3:0] sc_next;
    logic [2:0] bi;
    logic [7:0] shreg;
    logic       s7;
    logic       par_bad;
    logic       bit_val;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign sc_next = (sc == SC_LAST) ? 4'd0 : sc + 4'd1;

    // Capture the offset-7 sample so the decision at offset 8 uses a registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s7 <= 1'b1;
        end else if (sc == SC_PRE) begin
            s7 <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SC_EARLY = 4'd6;
    logic s6;

    // Capture the offset-6 sample for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s6 <= 1'b1;
        end else if (sc == SC_EARLY) begin
            s6 <= rx_s;
        end
    end

    assign bit_val = maj3(s6, s7, rx_s);
`else
    assign bit_val = s7;
`endif

    // Frame sequencer: arming, start detection, bit assembly and result delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARM;
            arm_cnt    <= 4'd0;
            sc         <= 4'd0;
            bi         <= 3'd0;
            shreg      <= 8'h00;
            par_bad    <= 1'b0;
            dataout    <= 8'h00;
            rdsig      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            idle       <= 1'b0;
        end else begin
            rdsig <= 1'b0;
            case (state)
                ST_ARM: begin
                    // A low sample (line driven 0 or in break) restarts the count.
                    if (!rx_s) begin
                        arm_cnt <= 4'd0;
                    end else if (arm_cnt == ARM_LAST) begin
                        arm_cnt <= 4'd0;
                        state   <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + 4'd1;
                    end
                end
                ST_IDLE: begin
                    // The cycle the low level is first seen is offset 0 of the start bit.
                    if (!rx_s) begin
                        state <= ST_START;
                        sc    <= 4'd1;
                        bi    <= 3'd0;
                        idle  <= 1'b1;
                    end else begin
                        sc <= 4'd0;
                    end
                end
                ST_START: begin
                    sc <= sc_next;
                    if (sc == SC_MID && bit_val) begin
                        state <= ST_IDLE;
                        sc    <= 4'd0;
                        idle  <= 1'b0;
                    end else if (sc == SC_LAST) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    sc <= sc_next;
                    if (sc == SC_MID) begin
                        shreg[bi] <= bit_val;
                    end
                    if (sc == SC_LAST) begin
                        bi <= bi + 3'd1;
                        if (bi == BI_LAST) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    sc <= sc_next;
                    if (sc == SC_MID) begin
                        par_bad <= bit_val ^ (^shreg) ^ PARITYMODE;
                    end
                    if (sc == SC_LAST) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    sc <= sc_next;
                    // Leaving at offset 9 lets a back-to-back start edge be caught early.
                    if (sc == SC_MID) begin
                        dataout    <= shreg;
                        rdsig      <= 1'b1;
                        parity_err <= par_bad;
                        frame_err  <= ~bit_val;
                        idle       <= 1'b0;
                        sc         <= 4'd0;
                        bi         <= 3'd0;
                        state      <= bit_val ? ST_IDLE : ST_ARM;
                    end
                end
                default: begin
                    state <= ST_ARM;
                    sc    <= 4'd0;
                    idle  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartrx.sv
// tb_uartrx: directed + randomized frames into uartrx, checked against a
// waveform-sampling reference model of the receiver.
module tb_uartrx;

    localparam logic PM = 1'b0;
    localparam int   NW = 20000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       parity_err;
    logic       frame_err;
    logic       idle;

    uartrx #(.PARITYMODE(PM), .CLKS_PER_BIT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .dataout    (dataout),
        .rdsig      (rdsig),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    ev_t  evq[$];
    exp_t expq[$];
    logic wave  [NW];
    logic idlew [NW];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record idle per cycle and every rdsig event with the outputs seen alongside it.
    always @(negedge clk) begin
        if (cyc < NW) begin
            idlew[cyc] = idle;
            if (rdsig === 1'b1)
                evq.push_back('{cyc, dataout, parity_err, frame_err});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic b);
        rx = b;
        if (cyc < NW) wave[cyc] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_level(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    function automatic logic par(input logic [7:0] d);
        return (^d) ^ PM;
    endfunction

    // Drive one frame; glitch_at inverts one cycle, rst_at aborts with reset asserted.
    task automatic drive_frame(input logic [7:0] d, input logic pb, input logic sb,
                               input int stop_len, input int glitch_at, input int rst_at,
                               output int t0);
        logic [10:0] fr;
        logic        b;
        int          k;
        fr = {sb, pb, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 160 + stop_len; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                rx    = 1'b1;
                return;
            end
            k = (i / 16 > 10) ? 10 : i / 16;
            b = fr[k];
            if (i == glitch_at) b = ~b;
            step(b);
        end
    endtask

    task automatic push_exp(input int t, input logic [7:0] d, input logic pe, input logic fe);
        expq.push_back('{t, d, pe, fe});
    endtask

    // Reference: the line level at the middle of each 16-clock bit (rx domain).
    function automatic logic samp(input int t);
`ifdef UART_RX_MAJORITY_EN
        return (wave[t-1] & wave[t]) | (wave[t-1] & wave[t+1]) | (wave[t] & wave[t+1]);
`else
        return wave[t];
`endif
    endfunction

    task automatic model(input int t0, output logic [7:0] d, output logic pe, output logic fe);
        d = 8'h00;
        for (int k = 0; k < 8; k++) d[k] = samp(t0 + 16 * (k + 1) + 7);
        pe = samp(t0 + 16 * 9 + 7) ^ (^d) ^ PM;
        fe = ~samp(t0 + 16 * 10 + 7);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_dataout"}, 32'(dataout), 32'h00);
        chk({pfx, "_rdsig"}, 32'(rdsig), 32'h0);
        chk({pfx, "_parity_err"}, 32'(parity_err), 32'h0);
        chk({pfx, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({pfx, "_idle"}, 32'(idle), 32'h0);
    endtask

    initial begin
        int         t;
        int         tfs;
        int         ib;
        int         sl;
        logic [7:0] d;
        logic       flip;
        logic [7:0] g0;
        logic [7:0] g1;
        logic       gpe;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        drive_level(1'b1, 20);

        // Clean A5 frame
        drive_frame(8'hA5, par(8'hA5), 1'b1, 16, -1, -1, t);
        push_exp(t, 8'hA5, 1'b0, 1'b0);
        drive_level(1'b1, 4);

        // 01 with wrong parity bit
        drive_frame(8'h01, 1'b0, 1'b1, 16, -1, -1, t);
        push_exp(t, 8'h01, 1'b1, 1'b0);
        drive_level(1'b1, 4);

        // 4-clock low pulse: false start
        tfs = cyc;
        drive_level(1'b0, 4);
        drive_level(1'b1, 30);
        chk("false_start_idle_rise", 32'(idlew[tfs + 3]), 32'h1);
        chk("false_start_idle_fall", 32'(idlew[tfs + 14]), 32'h0);

        // 3C with low stop bit, break, short high, low again, then rearm
        drive_frame(8'h3C, par(8'h3C), 1'b0, 16, -1, -1, t);
        push_exp(t, 8'h3C, 1'b0, 1'b1);
        drive_level(1'b0, 100);
        drive_level(1'b1, 8);
        drive_level(1'b0, 30);
        drive_level(1'b1, 20);
        drive_frame(8'h42, par(8'h42), 1'b1, 16, -1, -1, t);
        push_exp(t, 8'h42, 1'b0, 1'b0);
        drive_level(1'b1, 4);

        // Reset during data bit 4
        d = 8'($urandom);
        drive_frame(d, par(d), 1'b1, 16, -1, 16 * 5 + 8, t);
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        repeat (2) step(1'b1);
        rst_n = 1'b1;
        drive_level(1'b1, 20);
        drive_frame(8'h5A, par(8'h5A), 1'b1, 16, -1, -1, t);
        push_exp(t, 8'h5A, 1'b0, 1'b0);
        drive_level(1'b1, 4);

        // Back-to-back 00 / FF, each with a 1-clock glitch mid data bit 3
`ifdef UART_RX_MAJORITY_EN
        g0 = 8'h00; g1 = 8'hFF; gpe = 1'b0;
`else
        g0 = 8'h08; g1 = 8'hF7; gpe = 1'b1;
`endif
        ib = expq.size();
        drive_frame(8'h00, par(8'h00), 1'b1, 9, 16 * 4 + 7, -1, t);
        push_exp(t, g0, gpe, 1'b0);
        drive_frame(8'hFF, par(8'hFF), 1'b1, 16, 16 * 4 + 7, -1, t);
        push_exp(t, g1, gpe, 1'b0);
        drive_level(1'b1, 4);

        // Random frames, random parity faults, random spacing down to the minimum
        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            sl   = $urandom_range(9, 24);
            drive_frame(d, par(d) ^ flip, 1'b1, sl, -1, -1, t);
            push_exp(t, d, flip, 1'b0);
            drive_level(1'b1, $urandom_range(0, 5));
        end
        drive_level(1'b1, 200);

        chk("event_count", 32'(evq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            logic [7:0] md;
            logic       mpe;
            logic       mfe;
            int         ft;
            ft = expq[i].t;
            model(ft, md, mpe, mfe);
            chk($sformatf("f%0d_rdsig_cycle", i), 32'(evq[i].cyc), 32'(ft + 171));
            chk($sformatf("f%0d_model_data", i), 32'(evq[i].d), 32'(md));
            chk($sformatf("f%0d_model_perr", i), 32'(evq[i].pe), 32'(mpe));
            chk($sformatf("f%0d_model_ferr", i), 32'(evq[i].fe), 32'(mfe));
            chk($sformatf("f%0d_data", i), 32'(evq[i].d), 32'(expq[i].d));
            chk($sformatf("f%0d_perr", i), 32'(evq[i].pe), 32'(expq[i].pe));
            chk($sformatf("f%0d_ferr", i), 32'(evq[i].fe), 32'(expq[i].fe));
            chk($sformatf("f%0d_idle_before", i), 32'(idlew[ft + 2]), 32'h0);
            chk($sformatf("f%0d_idle_rise", i), 32'(idlew[ft + 3]), 32'h1);
            chk($sformatf("f%0d_idle_hold", i), 32'(idlew[ft + 170]), 32'h1);
            chk($sformatf("f%0d_idle_fall", i), 32'(idlew[ft + 171]), 32'h0);
        end
        if (evq.size() > ib + 1)
            chk("b2b_gap", 32'(evq[ib + 1].cyc - evq[ib].cyc), 32'd169);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uartrx.md
# uartrx

UART receive stage that consumes the serial stream produced by the design's transmitter: 16 clocks per bit, one start bit, 8 data bits LSB first, one parity bit, one stop bit. It synchronises and oversamples the `rx` line, checks parity and framing, and delivers each byte with a one-cycle strobe. It sits between the board RX pin, or the transmitter's `tx` in loopback, and the byte consumer.

## Interface
- `PARITYMODE`, default 1'b0: parity seed. Expected parity is `^data ^ PARITYMODE`, so 0 gives even parity and 1 gives odd parity. Must match the transmitter's setting.
- `CLKS_PER_BIT`, default 16: oversampling ratio. Fixed at 16 for this release; the sample offsets below assume it.
- `clk`  input  1: UART clock, the same clock the transmitter uses.
- `rst_n`  input  1: reset; asynchronous, active-low.
- `rx`  input  1: serial line, asynchronous to `clk`.
- `dataout`  output  8: last received byte.
- `rdsig`  output  1: one-cycle strobe when `dataout` and both error flags update.
- `parity_err`  output  1: parity mismatch on the last frame; valid from `rdsig`, held until the next `rdsig`.
- `frame_err`  output  1: stop bit sampled low on the last frame; same validity as `parity_err`.
- `idle`  output  1: high while a frame is being received, low otherwise. Same polarity as the transmitter's `idle`.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All logic below uses `rx_s`.
- Reset values: `dataout`=8'h00, `rdsig`=0, `parity_err`=0, `frame_err`=0, `idle`=0, state=ARM, all counters 0.
- States:
  - ARM: wait for `rx_s` high for 16 consecutive clocks, then go to IDLE. Any low sample restarts the count. This covers the transmitter driving 0 out of reset, and a line held in break.
  - IDLE: when `rx_s`=0, go to START, clear the 4-bit sample counter `sc` and the bit index `bi`, and set `idle`=1.
  - START: at `sc`=8, if the sampled bit is 1 (false start), return to IDLE and set `idle`=0. Otherwise continue to DATA.
  - DATA: 8 bits. Bit `bi` is decided at `sc`=8 and shifted into position [`bi`], LSB first.
  - PARITY: the bit is decided at `sc`=8 and compared with the expected parity.
  - STOP: the bit is decided at `sc`=8. On the next clock: load `dataout`, pulse `rdsig`, update the error flags, set `idle`=0. Then go to IDLE if the stop bit was 1, or to ARM if it was 0.
- `sc` wraps 15→0 at each bit boundary, and `bi` advances on that wrap.
- The bit decision is always made at `sc`=8, whatever the build configuration (see Configuration).
- Back-to-back frames: returning to IDLE at stop offset 9 lets the next falling edge be detected anywhere from there onward.
- A reset mid-frame aborts the frame without a `rdsig` and returns to ARM.

## Timing
- Falling edge on `rx` at cycle T: `rx_s` falls at T+2.
- `rdsig` is high in cycle T+2+169, and the updated `dataout` and flags are visible in that same cycle.
- `idle` rises in cycle T+3 and falls in the `rdsig` cycle.
- The outputs are registered, with no combinational path from `rx`.
- The shortest frame spacing is 169 clocks, which is the transmitter's minimum; no frame is dropped at that spacing.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit is the 2-of-3 majority of samples at `sc`=6,7,8. This also applies to the start-bit check.
- `UART_RX_MAJORITY_EN` undefined: each bit is the single sample at `sc`=7, registered and used at `sc`=8.
- Latency is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the state enum (ARM, IDLE, START, DATA, PARITY, STOP);
  - `UART_OSR`=16;
  - `UART_DATA_BITS`=8;
  - the default `PARITYMODE`.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer, which resets to 1. The rest lives in `uartrx`.

## Test plan
- Loopback from the transmitter with 8'hA5 → one `rdsig`, `dataout`=8'hA5, `parity_err`=0, `frame_err`=0, `rdsig` at T+171.
- Hand-driven frame with data 8'h01 and parity bit 0 (PARITYMODE=0) → `dataout`=8'h01, `parity_err`=1, `frame_err`=0.
- Frame 8'h3C with stop bit 0, then line held low for 100 clocks, then high → `frame_err`=1 and no further frame until 16 high clocks; a following 8'h42 frame is received cleanly.
- `rx` low pulse of 4 clocks from idle → no `rdsig`, `idle` back to 0 within 10 clocks.
- `rst_n` asserted during data bit 4 → all outputs at reset values, no `rdsig`; next frame 8'h5A is received correctly.
- Back-to-back 8'h00 then 8'hFF with a 1-clock glitch at `sc`=7 of bit 3 → 2 `rdsig` pulses 169 clocks apart. With `UART_RX_MAJORITY_EN`: exact bytes. Without it: bit 3 is corrupted (8'h08 / 8'hF7), and `parity_err` reads 1 on each of those two frames.
